// File: rtl/core_ctrl_pkg.sv
// Shared constants for the core sequencer: state encodings, widths.
package core_ctrl_pkg;

  localparam int CORE_XLEN = 32;
  localparam int TMO_W     = 8;

  localparam logic [2:0] CTRL_IDLE   = 3'd0;
  localparam logic [2:0] CTRL_FETCH  = 3'd1;
  localparam logic [2:0] CTRL_DECODE = 3'd2;
  localparam logic [2:0] CTRL_EXEC   = 3'd3;
  localparam logic [2:0] CTRL_MEM    = 3'd4;
  localparam logic [2:0] CTRL_WB     = 3'd5;
  localparam logic [2:0] CTRL_HALT   = 3'd6;
  localparam logic [2:0] CTRL_ERR    = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE   = CTRL_IDLE,
    S_FETCH  = CTRL_FETCH,
    S_DECODE = CTRL_DECODE,
    S_EXEC   = CTRL_EXEC,
    S_MEM    = CTRL_MEM,
    S_WB     = CTRL_WB,
    S_HALT   = CTRL_HALT,
    S_ERR    = CTRL_ERR
  } ctrl_state_e;

endpackage

// File: rtl/core_ctrl_if.sv
// Instruction and data memory handshakes seen from the core sequencer.
interface core_ctrl_if
  import core_ctrl_pkg::*;
#(
  parameter int XLEN = CORE_XLEN
);
  logic            ifetch_req_o;
  logic [XLEN-1:0] ifetch_addr_o;
  logic            ifetch_ack_i;
  logic [31:0]     ifetch_rdata_i;
  logic            dmem_req_o;
  logic            dmem_we_o;
  logic            dmem_ack_i;

  // core side drives requests
  modport master (
    output ifetch_req_o, ifetch_addr_o, dmem_req_o, dmem_we_o,
    input  ifetch_ack_i, ifetch_rdata_i, dmem_ack_i
  );

  // memory side answers them
  modport slave (
    input  ifetch_req_o, ifetch_addr_o, dmem_req_o, dmem_we_o,
    output ifetch_ack_i, ifetch_rdata_i, dmem_ack_i
  );
endinterface

// File: rtl/core_ctrl_wdog.sv
// Wait watchdog: counts unacknowledged wait cycles, flags the last allowed one.
module core_ctrl_wdog
  import core_ctrl_pkg::*;
#(
  parameter int LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  output logic hit
);
  localparam logic [TMO_W-1:0] LAST = TMO_W'(LIMIT - 1);

  logic [TMO_W-1:0] cnt;

  // clear outside a wait, advance on every cycle still waiting
  always_ff @(posedge clk_i) begin
    if (rst_i || clr) cnt <= '0;
    else if (en)      cnt <= cnt + 1'b1;
  end

  assign hit = (cnt == LAST);
endmodule

// File: rtl/core_ctrl.sv
// Multi-cycle RV32 sequencer: fetch/decode/exec/mem/wb, owns PC and IR.
module core_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int              XLEN     = CORE_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
  parameter int              TIMEOUT  = 255
) (
  input  logic             clk_i,
  input  logic             rst_i,
  core_ctrl_if.master      bus,
  output logic [31:0]      instr_o,
  input  logic             is_load_i,
  input  logic             is_store_i,
  input  logic             rd_wen_i,
  input  logic             ebreak_i,
  input  logic [XLEN-1:0]  next_pc_i,
  output logic             rf_wen_o,
  output logic [XLEN-1:0]  pc_o,
  output logic             halt_o,
  output logic             err_o,
  output logic [2:0]       state_o
);
  ctrl_state_e     state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic [31:0]     instr_q;
  logic            load_q, store_q, rdw_q;
  logic            wait_st, wait_ack, wd_hit;

  // only the ack belonging to the current wait state counts
  assign wait_st  = (state_q == S_FETCH) || (state_q == S_MEM);
  assign wait_ack = (state_q == S_FETCH) ? bus.ifetch_ack_i : bus.dmem_ack_i;

  core_ctrl_wdog #(.LIMIT(TIMEOUT)) u_wdog (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr   (!wait_st),
    .en    (wait_st && !wait_ack),
    .hit   (wd_hit)
  );

  // state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // next state and registered-state output decode
  always_comb begin
    state_d          = state_q;
    bus.ifetch_req_o = 1'b0;
    bus.dmem_req_o   = 1'b0;
    bus.dmem_we_o    = 1'b0;
    rf_wen_o         = 1'b0;
    halt_o           = 1'b0;
    err_o            = 1'b0;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        bus.ifetch_req_o = 1'b1;
        if (bus.ifetch_ack_i) state_d = S_DECODE;
        else if (wd_hit)      state_d = S_ERR;
      end
      S_DECODE: state_d = ebreak_i ? S_HALT : S_EXEC;
      S_EXEC:   state_d = (load_q || store_q) ? S_MEM : S_WB;
      S_MEM: begin
        bus.dmem_req_o = 1'b1;
        bus.dmem_we_o  = store_q;
        if (bus.dmem_ack_i) state_d = S_WB;
        else if (wd_hit)    state_d = S_ERR;
      end
      S_WB: begin
        rf_wen_o = rdw_q && !store_q;
        state_d  = S_FETCH;
      end
      S_HALT:   halt_o = 1'b1;
      S_ERR:    err_o  = 1'b1;
    endcase
  end

  // PC, instruction register and decoder flag latches
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q    <= RESET_PC;
      instr_q <= '0;
      load_q  <= 1'b0;
      store_q <= 1'b0;
      rdw_q   <= 1'b0;
    end else begin
      if (state_q == S_FETCH && bus.ifetch_ack_i) instr_q <= bus.ifetch_rdata_i;
      if (state_q == S_DECODE) begin
        load_q  <= is_load_i;
        store_q <= is_store_i;
        rdw_q   <= rd_wen_i;
      end
      if (state_q == S_WB) pc_q <= next_pc_i;
    end
  end

  assign bus.ifetch_addr_o = pc_q;
  assign pc_o              = pc_q;
  assign instr_o           = instr_q;
  assign state_o           = state_q;
endmodule

// File: tb/tb_core_ctrl.sv
// Randomized instruction-level bench for core_ctrl with a transaction model.
module tb_core_ctrl;
  localparam int          TMO  = 4;
  localparam logic [31:0] RPC  = 32'h8000_0000;
  localparam logic [2:0]  S_IDLE = 3'd0, S_FETCH = 3'd1, S_HALT = 3'd6, S_ERR = 3'd7;
  localparam int K_ALU = 0, K_LOAD = 1, K_STORE = 2, K_EBRK = 3;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [31:0] instr_o, next_pc_i, pc_o;
  logic        is_load_i = 0, is_store_i = 0, rd_wen_i = 0, ebreak_i = 0;
  logic        rf_wen_o, halt_o, err_o;
  logic [2:0]  state_o;

  int          n_checks = 0, n_errs = 0;
  logic [31:0] m_pc, m_instr;

  core_ctrl_if #(.XLEN(32)) mif ();

  core_ctrl #(.XLEN(32), .RESET_PC(RPC), .TIMEOUT(TMO)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .bus       (mif),
    .instr_o   (instr_o),
    .is_load_i (is_load_i),
    .is_store_i(is_store_i),
    .rd_wen_i  (rd_wen_i),
    .ebreak_i  (ebreak_i),
    .next_pc_i (next_pc_i),
    .rf_wen_o  (rf_wen_o),
    .pc_o      (pc_o),
    .halt_o    (halt_o),
    .err_o     (err_o),
    .state_o   (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reset with stale acks asserted; they must not leak into the first fetch
  task automatic do_reset();
    rst_i = 1'b1;
    mif.ifetch_ack_i = 1'b1; mif.dmem_ack_i = 1'b1; mif.ifetch_rdata_i = 32'hdead_beef;
    @(negedge clk); @(negedge clk);
    chk("rst_state", state_o, S_IDLE);
    chk("rst_pc", pc_o, RPC);
    chk("rst_instr", instr_o, 0);
    chk("rst_outs", {mif.ifetch_req_o, mif.dmem_req_o, rf_wen_o, halt_o, err_o}, 0);
    m_pc = RPC; m_instr = 0;
    rst_i = 1'b0;
    @(negedge clk);
    chk("rel_ifetch_req", mif.ifetch_req_o, 1);
    chk("rel_state", state_o, S_FETCH);
    chk("rel_instr", instr_o, 0);
  endtask

  // after HALT/ERR: nothing moves regardless of acks
  task automatic idle_check(input logic [2:0] st, input int n);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      mif.ifetch_ack_i = 1'($urandom_range(1, 0));
      mif.dmem_ack_i   = 1'($urandom_range(1, 0));
      @(negedge clk);
      if (mif.ifetch_req_o || mif.dmem_req_o || rf_wen_o || state_o != st || pc_o != m_pc) bad++;
    end
    chk("idle_quiet", bad, 0);
  endtask

  // One instruction from FETCH entry. fw/mw = wait cycles before ack
  // (>= TMO means the ack never comes).
  task automatic run_instr(input int kind, input int fw, input int mw, input bit rdw,
                           input logic [31:0] word, input logic [31:0] npc);
    bit mem, left, done;
    int cyc, nf, nm, nwe, nw, e_cyc, e_nm, e_nw;
    logic [2:0] e_st;
    mem = (kind == K_LOAD) || (kind == K_STORE);
    if (fw >= TMO)                 begin e_st = S_ERR;   e_cyc = TMO; end
    else if (kind == K_EBRK)       begin e_st = S_HALT;  e_cyc = fw + 2; end
    else if (mem && mw >= TMO)     begin e_st = S_ERR;   e_cyc = fw + 3 + TMO; end
    else                           begin e_st = S_FETCH; e_cyc = fw + 4 + (mem ? mw + 1 : 0); end
    e_nm = 0;
    if (mem && fw < TMO) e_nm = (mw >= TMO) ? TMO : mw + 1;
    e_nw = (e_st == S_FETCH && kind != K_STORE && rdw) ? 1 : 0;

    chk("start_state", state_o, S_FETCH);
    chk("fetch_addr", mif.ifetch_addr_o, m_pc);
    is_load_i = (kind == K_LOAD); is_store_i = (kind == K_STORE);
    rd_wen_i = rdw; ebreak_i = (kind == K_EBRK); next_pc_i = npc;
    cyc = 0; nf = 0; nm = 0; nwe = 0; nw = 0; left = 0; done = 0;
    while (!done && cyc < 64) begin
      if (mif.ifetch_req_o) nf++;
      if (mif.dmem_req_o) begin
        nm++;
        if (mif.dmem_we_o == (kind == K_STORE)) nwe++;
      end
      if (rf_wen_o) nw++;
      mif.ifetch_ack_i   = mif.ifetch_req_o ? (nf == fw + 1) : 1'($urandom_range(1, 0));
      mif.ifetch_rdata_i = (mif.ifetch_req_o && mif.ifetch_ack_i) ? word : $urandom;
      mif.dmem_ack_i     = mif.dmem_req_o ? (nm == mw + 1) : 1'($urandom_range(1, 0));
      @(negedge clk);
      cyc++;
      if (state_o == S_HALT || state_o == S_ERR) done = 1;
      else if (state_o != S_FETCH) left = 1;
      else if (left) done = 1;
    end
    if (e_st == S_FETCH) m_pc = npc;
    if (fw < TMO) m_instr = word;
    chk("instr_done", done, 1);
    chk("cycles", cyc, e_cyc);
    chk("end_state", state_o, e_st);
    chk("ifetch_cycles", nf, (fw >= TMO) ? TMO : fw + 1);
    chk("dmem_cycles", nm, e_nm);
    chk("dmem_we", nwe, nm);
    chk("rf_wen_pulses", nw, e_nw);
    chk("pc", pc_o, m_pc);
    chk("instr", instr_o, m_instr);
    chk("halt", halt_o, e_st == S_HALT);
    chk("err", err_o, e_st == S_ERR);
  endtask

  initial begin
    mif.ifetch_ack_i = 0; mif.dmem_ack_i = 0; mif.ifetch_rdata_i = 0; next_pc_i = 0;
    do_reset();
    // addi, zero-wait fetch, pc+4
    run_instr(K_ALU, 0, 0, 1, 32'h0010_0093, RPC + 32'd4);
    chk("addi_pc", pc_o, 32'h8000_0004);
    // load with 3-cycle data wait, store with rd_wen set
    run_instr(K_LOAD, 1, 3, 1, 32'h0000_2103, m_pc + 32'd4);
    run_instr(K_STORE, 0, 2, 1, 32'h0020_2023, m_pc + 32'd4);
    // fetch timeout, then ack exactly on the limit cycle
    run_instr(K_ALU, TMO, 0, 1, 32'h1234_5678, m_pc + 32'd4);
    idle_check(S_ERR, 10);
    do_reset();
    run_instr(K_ALU, TMO - 1, 0, 1, 32'h0010_0093, m_pc + 32'd4);
    // data timeout, then data ack on the limit cycle
    run_instr(K_LOAD, 0, TMO, 1, 32'h0000_2103, m_pc + 32'd4);
    idle_check(S_ERR, 10);
    do_reset();
    run_instr(K_STORE, 2, TMO - 1, 0, 32'h0020_2023, m_pc + 32'd4);
    // PC wrap is just another next_pc value
    run_instr(K_ALU, 0, 0, 1, $urandom, 32'hffff_fffc);
    run_instr(K_ALU, 0, 0, 0, $urandom, m_pc + 32'd4);
    chk("wrap_pc", pc_o, 32'h0000_0000);
    // random traffic
    for (int i = 0; i < 40; i++)
      run_instr($urandom_range(2, 0), $urandom_range(TMO - 1, 0), $urandom_range(TMO - 1, 0),
                1'($urandom_range(1, 0)), $urandom, $urandom);
    // reset while a load is waiting in MEM; a late ack must be ignored
    is_load_i = 1; is_store_i = 0; rd_wen_i = 1; ebreak_i = 0;
    mif.ifetch_ack_i = 1; mif.dmem_ack_i = 0; mif.ifetch_rdata_i = 32'h0000_2103;
    @(negedge clk); mif.ifetch_ack_i = 0;
    @(negedge clk); @(negedge clk);
    chk("mem_req_before_rst", mif.dmem_req_o, 1);
    rst_i = 1;
    @(negedge clk);
    chk("rst_mem_req", mif.dmem_req_o, 0);
    chk("rst_mem_state", state_o, S_IDLE);
    chk("rst_mem_pc", pc_o, RPC);
    rst_i = 0; mif.dmem_ack_i = 1;
    @(negedge clk);
    chk("late_ack_state", state_o, S_FETCH);
    chk("late_ack_req", mif.dmem_req_o, 0);
    m_pc = RPC; m_instr = 0;
    run_instr(K_ALU, 1, 0, 1, 32'h0010_0093, RPC + 32'd4);
    // ebreak with rd_wen high: halt, no write, pc frozen
    run_instr(K_EBRK, 1, 0, 1, 32'h0010_0073, 32'h1111_1111);
    idle_check(S_HALT, 20);
    chk("halt_sticky", halt_o, 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

  // hard stop if something wedges the sequence itself
  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end
endmodule

// File: doc/core_ctrl.md
Name: core_ctrl

Overview:
- Multi-cycle sequencer for the RV32 core datapath (decoder, register file, execute unit, PC).
- Owns the PC and the latched instruction register.
- Sequences fetch, decode, execute, memory and writeback, and drives handshakes to instruction and data memory.
- Gates register-file writes so each instruction writes exactly once, and stops the core on ebreak or on a memory timeout.

Parameters:
XLEN, 32, datapath/PC width
RESET_PC, 32'h8000_0000, PC value loaded on reset
TIMEOUT, 255, max cycles waiting for any memory ack before error (1..255)

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  synchronous reset, active-high
ifetch_req_o  out  1  instruction fetch request, held until ack
ifetch_addr_o  out  XLEN  fetch address (= pc_o)
ifetch_ack_i  in  1  fetch complete; ifetch_rdata_i valid this cycle
ifetch_rdata_i  in  32  fetched instruction
instr_o  out  32  latched instruction to decoder
is_load_i  in  1  decoder: load
is_store_i  in  1  decoder: store
rd_wen_i  in  1  decoder: instruction writes rd
ebreak_i  in  1  decoder: ebreak
next_pc_i  in  XLEN  next PC from execute/branch logic
dmem_req_o  out  1  data memory request, held until ack
dmem_we_o  out  1  1 = store, 0 = load; valid while dmem_req_o=1
dmem_ack_i  in  1  data access complete
rf_wen_o  out  1  register-file write enable, one-cycle pulse
pc_o  out  XLEN  current PC
halt_o  out  1  core halted by ebreak (sticky)
err_o  out  1  memory timeout (sticky)
state_o  out  3  current state encoding, for debug

Behaviour:
- States and encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, ERR=7.
- Reset (rst_i=1 at a rising edge):
  - state=IDLE, pc=RESET_PC, instr=0, latched flags=0, timeout counter=0.
  - All request, write-enable and status outputs are 0.
  - Reset mid-operation aborts any in-flight request; requests drop after that edge.
- IDLE -> FETCH unconditionally on the next edge.
- FETCH:
  - ifetch_req_o=1, ifetch_addr_o=pc.
  - On ifetch_ack_i: latch ifetch_rdata_i into instr, go to DECODE.
  - An ack in the same cycle the request is first raised is accepted.
- DECODE:
  - Latch is_load_i, is_store_i, rd_wen_i.
  - ebreak_i=1 -> HALT, with no PC update and no register write.
  - Otherwise -> EXEC.
- EXEC: one-cycle settle slot for the execute unit. Goes to MEM if latched load or store, else to WB.
- MEM:
  - dmem_req_o=1, dmem_we_o=latched store.
  - On dmem_ack_i -> WB.
- WB:
  - rf_wen_o = latched rd_wen & ~latched store, for exactly one cycle.
  - pc <= next_pc_i at the exit edge; next state FETCH.
- HALT: halt_o=1; stays until reset; no requests.
- ERR: err_o=1; stays until reset; no requests.
- Acks:
  - ifetch_ack_i and dmem_ack_i are ignored in every state other than FETCH and MEM respectively (stale acks after reset have no effect).
  - Simultaneous acks: only the one matching the current state is used.
- Timeout:
  - 8-bit counter cleared on entry to FETCH and to MEM; increments each cycle spent waiting without an ack.
  - When counter == TIMEOUT-1 and no ack -> ERR.
  - An ack on the same cycle the limit is reached wins: no error.
- Latency:
  - Non-memory instruction with zero-wait ack: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load/store: 5 cycles plus memory wait.
- PC arithmetic is modulo 2^XLEN; the PC wraps with no special handling.
- Outputs are decoded from registered state only; there are no combinational input-to-output paths, except ifetch_addr_o = pc.

Decomposition:
- Shared package holds:
  - state encoding localparams (CTRL_IDLE..CTRL_ERR, width 3);
  - TIMEOUT counter width;
  - XLEN, from the existing global defines.
- One sub-module is natural: core_ctrl_wdog, the clear/enable timeout counter with a limit-reached output, reused for both the fetch and memory waits.

Test Plan:
- Reset release, ack tied high: instr 0x00100093 (addi), next_pc_i=pc+4.
  -> ifetch_req_o rises on cycle 1 after release; states 1,2,3,5; rf_wen_o pulses once; pc 0x80000000 -> 0x80000004.
- Load with dmem_ack_i delayed 3 cycles.
  -> dmem_req_o=1, dmem_we_o=0 for 4 cycles; rf_wen_o pulses in WB; 8 cycles from FETCH entry to next FETCH.
- Store (is_store_i=1, rd_wen_i=1).
  -> dmem_we_o=1 in MEM; rf_wen_o stays 0; pc advances.
- ebreak_i=1 in DECODE.
  -> state 6, halt_o=1, pc unchanged, no further requests for 20 cycles.
- ifetch_ack_i never arrives, TIMEOUT=4.
  -> ERR after 4 FETCH cycles, err_o=1. Repeat with ack on the 4th cycle -> DECODE, err_o=0.
- rst_i asserted while in MEM with dmem_req_o=1.
  -> dmem_req_o=0 next cycle, state IDLE, pc=RESET_PC; a late dmem_ack_i is ignored.
